tiny_alu_mc: RTL and testbench
==============================

# tiny_alu_mc

Parametrised multi-cycle ALU, successor to the 8-bit tiny ALU in the primer design set. It accepts one operation per start/done handshake on a single clock and computes ADD, AND, XOR, SUB and MUL on WIDTH-bit unsigned operands into a 2*WIDTH-bit result. Logic ops complete in one cycle; MUL runs a configurable number of cycles. It serves as the DUT for the UVM primer benches: driver on the start side, monitor on done/result.

## Interface
- WIDTH, 8: operand width in bits, ≥ 2.
- MUL_LAT, 3: multiply latency in cycles from accept to done, ≥ 1.

- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  synchronous reset, active-high.
- start  in  1  request; sampled on the rising edge.
- op  in  3  opcode, sampled with start.
- A  in  WIDTH  operand A, sampled with start.
- B  in  WIDTH  operand B, sampled with start.
- busy  out  1  operation in flight; start is ignored while high.
- done  out  1  one-cycle pulse; result and err are valid in that cycle.
- err  out  1  qualified by done; 1 = illegal opcode.
- result  out  2*WIDTH  result of the last completed op; held until the next done.

## Operation
- Opcodes:
  - 000 NOP
  - 001 ADD
  - 010 AND
  - 011 XOR
  - 100 MUL
  - 101 SUB
  - 110, 111 illegal
- States: IDLE, EXEC, MUL. done is a registered pulse, not a state.
- Accept:
  - Occurs when start=1 and busy=0 on a rising edge.
  - A, B and op are latched into internal registers. Later changes on the input ports have no effect on the op in flight.
- NOP accepted: no state change, busy stays 0, no done, result unchanged.
- ADD/AND/XOR/SUB/illegal accepted: IDLE→EXEC; busy=1 for 1 cycle.
- MUL accepted:
  - IDLE→MUL; down-counter loaded with MUL_LAT-1; busy=1 for MUL_LAT cycles.
  - MUL_LAT=1 behaves exactly like EXEC.
- Completion edge: state→IDLE; busy→0; done→1 for one cycle; result and err updated.
- Arithmetic, all unsigned:
  - ADD: result = zero-extend(A+B); bit WIDTH = carry.
  - SUB: result[WIDTH-1:0] = (A-B) mod 2^WIDTH; result[WIDTH] = borrow (A<B); upper bits 0.
  - AND, XOR: low WIDTH bits; upper bits 0.
  - MUL: full 2*WIDTH-bit product, never truncated.
- Illegal op: done=1, err=1, result holds its previous value.
- err=0 on every legal completion.
- start while busy=1: ignored and not queued; no error.
- Back-to-back: busy is 0 in the done cycle, so start in that cycle is accepted. Sustained ALU throughput is one op every 2 cycles.

## Timing
- Reset (rst=1 at a rising edge), outputs after that edge:
  - busy=0, done=0, err=0, result=0; state=IDLE; counter=0.
  - rst overrides start in the same cycle.
- Reset mid-operation aborts the op: no done is ever produced for it, and result is zeroed.
- Accept at edge k:
  - ALU/illegal: busy=1 after edge k; done=1 and result valid after edge k+1.
  - MUL: done after edge k+MUL_LAT.
- done is high for exactly one cycle per accepted non-NOP op. It is never asserted twice for one op and never asserted without a prior accept.
- busy and done are never both 1.
- start is a level: if held high, a new op is accepted on every edge where busy=0.
- After rst deasserts, the first start is accepted on the next rising edge.

## Test plan
Configuration: WIDTH=8, MUL_LAT=3.
- Reset: assert rst for 2 cycles while driving start=1, op=001.
  - Required: busy=0, done=0, err=0, result=16'h0000 throughout; no done after rst falls until a new accept.
- ALU: ADD A=8'hFF, B=8'h01, then SUB A=8'h03, B=8'h05 in the done cycle of the ADD.
  - Required: result 16'h0100 with done at k+1.
  - Required: result 16'h01FE with done 2 cycles later; err=0 on both.
- MUL: MUL A=8'hFF, B=8'hFF.
  - Required: busy=1 for 3 cycles; done at k+3 with result 16'hFE01.
  - Required: a start with op=001 at k+1 is ignored, and no extra done follows.
- NOP and illegal: NOP, then op=110 with result previously 16'h0055.
  - Required: NOP gives no busy and no done.
  - Required: the illegal op gives done=1, err=1 at k+1 and result stays 16'h0055.
- Reset mid-MUL: accept MUL 8'h10×8'h10, assert rst at k+1.
  - Required: no done at k+3 and result=0; a subsequent AND 8'hF0&8'h3C gives 16'h0030.
- Operand stability: change A and B on every cycle during a MUL 8'h0C×8'h0A.
  - Required: result 16'h0078, computed from the latched operands.

Source files
------------

// File: rtl/tiny_alu_mc.sv
// ---------------------------------------------------------------------------
// tiny_alu_mc
//   Multi-cycle unsigned ALU with a start/done handshake. One operation is
//   accepted when i_start is high and the unit is idle. ADD, AND, XOR, SUB
//   and illegal opcodes complete one cycle after accept. MUL completes
//   MUL_LAT cycles after accept. NOP is accepted silently and produces no
//   completion.
//
// Ports
//   i_clk     clock, rising edge
//   i_rst     synchronous reset, active-high
//   i_start   request, sampled on the rising edge
//   i_op      opcode (000 NOP, 001 ADD, 010 AND, 011 XOR, 100 MUL, 101 SUB)
//   i_a, i_b  WIDTH-bit unsigned operands, latched on accept
//   o_busy    operation in flight; i_start is ignored while high
//   o_done    one-cycle completion pulse
//   o_err     qualified by o_done; 1 = illegal opcode
//   o_result  2*WIDTH-bit result of the last legal completed op
// ---------------------------------------------------------------------------
module tiny_alu_mc #(
   parameter int WIDTH   = 8,
   parameter int MUL_LAT = 3
) (
   input  logic                 i_clk,
   input  logic                 i_rst,
   input  logic                 i_start,
   input  logic [2:0]           i_op,
   input  logic [WIDTH-1:0]     i_a,
   input  logic [WIDTH-1:0]     i_b,
   output logic                 o_busy,
   output logic                 o_done,
   output logic                 o_err,
   output logic [2*WIDTH-1:0]   o_result
);

   localparam logic [2:0] OP_NOP = 3'b000;
   localparam logic [2:0] OP_ADD = 3'b001;
   localparam logic [2:0] OP_AND = 3'b010;
   localparam logic [2:0] OP_XOR = 3'b011;
   localparam logic [2:0] OP_MUL = 3'b100;
   localparam logic [2:0] OP_SUB = 3'b101;

   localparam int CNT_W = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;

   // SUB keeps the WIDTH-bit difference plus the borrow in bit WIDTH.
   localparam logic [2*WIDTH-1:0] SUB_MASK = {{(WIDTH-1){1'b0}}, {(WIDTH+1){1'b1}}};

   typedef enum logic [1:0] {
      S_IDLE,
      S_EXEC,
      S_MUL
   } state_t;

   state_t               r_state;
   logic [CNT_W-1:0]     r_cnt;
   logic [2:0]           r_op;
   logic [WIDTH-1:0]     r_a;
   logic [WIDTH-1:0]     r_b;
   logic                 r_busy;
   logic                 r_done;
   logic                 r_err;
   logic [2*WIDTH-1:0]   r_result;

   function automatic logic f_is_legal(input logic [2:0] op);
      return (op == OP_ADD) || (op == OP_AND) || (op == OP_XOR) ||
             (op == OP_MUL) || (op == OP_SUB);
   endfunction

   // Operands are zero-extended to the result width so that the carry of
   // ADD, the borrow of SUB and the full MUL product fall out naturally.
   function automatic logic [2*WIDTH-1:0] f_alu(input logic [2:0]       op,
                                               input logic [WIDTH-1:0] a,
                                               input logic [WIDTH-1:0] b);
      logic [2*WIDTH-1:0] za;
      logic [2*WIDTH-1:0] zb;
      logic [2*WIDTH-1:0] r;
      za = {{WIDTH{1'b0}}, a};
      zb = {{WIDTH{1'b0}}, b};
      case (op)
         OP_ADD:  r = za + zb;
         OP_AND:  r = za & zb;
         OP_XOR:  r = za ^ zb;
         OP_SUB:  r = (za - zb) & SUB_MASK;
         OP_MUL:  r = za * zb;
         default: r = '0;
      endcase
      return r;
   endfunction

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state  <= S_IDLE;
         r_cnt    <= '0;
         r_busy   <= 1'b0;
         r_done   <= 1'b0;
         r_err    <= 1'b0;
         r_result <= '0;
      end else begin
         r_done <= 1'b0;
         unique case (r_state)
            S_IDLE: begin
               if (i_start && (i_op != OP_NOP)) begin
                  r_op   <= i_op;
                  r_a    <= i_a;
                  r_b    <= i_b;
                  r_busy <= 1'b1;
                  if (i_op == OP_MUL) begin
                     // Counter expires after MUL_LAT-1 further cycles; with
                     // MUL_LAT=1 it starts at zero and completes like EXEC.
                     r_cnt   <= CNT_W'(MUL_LAT - 1);
                     r_state <= S_MUL;
                  end else begin
                     r_state <= S_EXEC;
                  end
               end
            end
            S_EXEC: begin
               r_state <= S_IDLE;
               r_busy  <= 1'b0;
               r_done  <= 1'b1;
               r_err   <= !f_is_legal(r_op);
               // An illegal op leaves the previous result in place.
               if (f_is_legal(r_op)) begin
                  r_result <= f_alu(r_op, r_a, r_b);
               end
            end
            S_MUL: begin
               if (r_cnt == '0) begin
                  r_state  <= S_IDLE;
                  r_busy   <= 1'b0;
                  r_done   <= 1'b1;
                  r_err    <= 1'b0;
                  r_result <= f_alu(OP_MUL, r_a, r_b);
               end else begin
                  r_cnt <= r_cnt - 1'b1;
               end
            end
            default: begin
               r_state <= S_IDLE;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

   assign o_busy   = r_busy;
   assign o_done   = r_done;
   assign o_err    = r_err;
   assign o_result = r_result;

endmodule

// File: tb/tb_tiny_alu_mc.sv
module tb_tiny_alu_mc;

   localparam int W   = 8;
   localparam int LAT = 3;
   localparam int RW  = 2 * W;

   localparam logic [2:0] NOP = 3'b000;
   localparam logic [2:0] ADD = 3'b001;
   localparam logic [2:0] AND = 3'b010;
   localparam logic [2:0] XOR = 3'b011;
   localparam logic [2:0] MUL = 3'b100;
   localparam logic [2:0] SUB = 3'b101;
   localparam logic [2:0] ILL = 3'b110;

   logic          clk;
   logic          rst;
   logic          start;
   logic [2:0]    op;
   logic [W-1:0]  a;
   logic [W-1:0]  b;
   logic          busy;
   logic          done;
   logic          err;
   logic [RW-1:0] result;

   tiny_alu_mc #(.WIDTH(W), .MUL_LAT(LAT)) dut (
      .i_clk    (clk),
      .i_rst    (rst),
      .i_start  (start),
      .i_op     (op),
      .i_a      (a),
      .i_b      (b),
      .o_busy   (busy),
      .o_done   (done),
      .o_err    (err),
      .o_result (result)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int            due;
      bit            err;
      logic [RW-1:0] res;
   } exp_t;

   exp_t          q[$];
   bit            rst_edge[0:8191];
   int            free_edge;
   logic [RW-1:0] model_res;
   logic [RW-1:0] held;
   int            n_chk  = 0;
   int            n_pass = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
      n_chk++;
      if (act !== expv)
         $display("FAIL %s at cycle %0d: got %h required %h", name, cyc, act, expv);
      else
         n_pass++;
   endtask

   // Reference: result per the arithmetic rules, computed with plain integers.
   function automatic logic [RW-1:0] ref_alu(input logic [2:0] o, input int ai, input int bi,
                                             input logic [RW-1:0] prev);
      int v;
      case (o)
         ADD:     v = ai + bi;
         AND:     v = ai & bi;
         XOR:     v = ai ^ bi;
         MUL:     v = ai * bi;
         SUB:     v = (ai < bi) ? (ai - bi + 2 * (1 << W)) : (ai - bi);
         default: return prev;
      endcase
      return RW'(v);
   endfunction

   // Sets inputs for the next rising edge and updates the reference model
   // for that edge. On return the DUT outputs reflect the previous edge.
   task automatic drive(input bit r, input bit s, input logic [2:0] o,
                        input logic [W-1:0] av, input logic [W-1:0] bv);
      int   e;
      exp_t x;
      exp_t keep[$];
      @(posedge clk);
      #1;
      e = cyc + 1;
      rst = r; start = s; op = o; a = av; b = bv;
      rst_edge[e] = r;
      if (r) begin
         foreach (q[i]) if (q[i].due < e) keep.push_back(q[i]);
         q = keep;
         model_res = '0;
         free_edge = e + 1;
      end else if (s && (e >= free_edge) && (o != NOP)) begin
         x.err = (o == ILL) || (o == 3'b111);
         x.res = ref_alu(o, int'(av), int'(bv), model_res);
         x.due = (o == MUL) ? e + LAT : e + 1;
         model_res = x.res;
         free_edge = x.due + 1;
         q.push_back(x);
      end
   endtask

   task automatic idle();
      drive(1'b0, 1'b0, NOP, '0, '0);
   endtask

   task automatic chk_out(input string name, input logic ebusy, input logic edone,
                          input logic eerr, input logic [RW-1:0] eres);
      chk({name, "_busy"}, 32'(busy), 32'(ebusy));
      chk({name, "_done"}, 32'(done), 32'(edone));
      if (edone) chk({name, "_err"}, 32'(err), 32'(eerr));
      chk({name, "_result"}, 32'(result), 32'(eres));
   endtask

   // Monitor: pops the scoreboard on every done and watches invariants.
   always @(negedge clk) begin
      exp_t x;
      if (cyc > 0) begin
         if (rst_edge[cyc]) begin
            chk("rst_busy", 32'(busy), 32'd0);
            chk("rst_done", 32'(done), 32'd0);
            chk("rst_err", 32'(err), 32'd0);
            chk("rst_result", 32'(result), 32'd0);
            held = '0;
         end else begin
            chk("busy_and_done", 32'(busy && done), 32'd0);
            if (done === 1'b1) begin
               if (q.size() == 0) begin
                  n_chk++;
                  $display("FAIL unexpected_done at cycle %0d: got done=1 required 0", cyc);
               end else begin
                  x = q.pop_front();
                  chk("done_cycle", 32'(cyc), 32'(x.due));
                  chk("sb_err", 32'(err), 32'(x.err));
                  chk("sb_result", 32'(result), 32'(x.res));
                  held = x.res;
               end
            end
            while (q.size() > 0 && q[0].due < cyc) begin
               n_chk++;
               $display("FAIL missing_done at cycle %0d: got none required done at %0d", cyc, q[0].due);
               void'(q.pop_front());
            end
            chk("result_held", 32'(result), 32'(held));
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      held = '0;
      model_res = '0;
      foreach (rst_edge[i]) rst_edge[i] = 1'b0;
      // Reset for two edges while requesting an ADD.
      rst = 1'b1; start = 1'b1; op = ADD; a = 8'h12; b = 8'h34;
      rst_edge[1] = 1'b1;
      free_edge = 2;
      drive(1'b1, 1'b1, ADD, 8'h12, 8'h34);
      chk_out("reset1", 1'b0, 1'b0, 1'b0, 16'h0000);
      idle();
      chk_out("reset2", 1'b0, 1'b0, 1'b0, 16'h0000);
      idle();
      chk_out("post_reset", 1'b0, 1'b0, 1'b0, 16'h0000);

      // ADD then SUB issued in the ADD's done cycle.
      drive(1'b0, 1'b1, ADD, 8'hFF, 8'h01);
      idle();
      chk_out("add_k", 1'b1, 1'b0, 1'b0, 16'h0000);
      drive(1'b0, 1'b1, SUB, 8'h03, 8'h05);
      chk_out("add_done", 1'b0, 1'b1, 1'b0, 16'h0100);
      idle();
      chk_out("sub_k", 1'b1, 1'b0, 1'b0, 16'h0100);
      idle();
      chk_out("sub_done", 1'b0, 1'b1, 1'b0, 16'h01FE);

      // MUL with an ignored start one cycle after accept.
      drive(1'b0, 1'b1, MUL, 8'hFF, 8'hFF);
      drive(1'b0, 1'b1, ADD, 8'h11, 8'h22);
      chk_out("mul_k", 1'b1, 1'b0, 1'b0, 16'h01FE);
      idle();
      chk_out("mul_k1", 1'b1, 1'b0, 1'b0, 16'h01FE);
      idle();
      chk_out("mul_k2", 1'b1, 1'b0, 1'b0, 16'h01FE);
      idle();
      chk_out("mul_done", 1'b0, 1'b1, 1'b0, 16'hFE01);
      idle();
      chk_out("mul_after1", 1'b0, 1'b0, 1'b0, 16'hFE01);
      idle();
      chk_out("mul_after2", 1'b0, 1'b0, 1'b0, 16'hFE01);

      // NOP and illegal opcode with result previously 16'h0055.
      drive(1'b0, 1'b1, AND, 8'h55, 8'hFF);
      idle();
      idle();
      chk_out("and55", 1'b0, 1'b1, 1'b0, 16'h0055);
      drive(1'b0, 1'b1, NOP, 8'hAA, 8'hBB);
      idle();
      chk_out("nop_k", 1'b0, 1'b0, 1'b0, 16'h0055);
      idle();
      chk_out("nop_k1", 1'b0, 1'b0, 1'b0, 16'h0055);
      drive(1'b0, 1'b1, ILL, 8'h12, 8'h34);
      idle();
      chk_out("ill_k", 1'b1, 1'b0, 1'b0, 16'h0055);
      idle();
      chk_out("ill_done", 1'b0, 1'b1, 1'b1, 16'h0055);

      // Reset during a MUL aborts it.
      drive(1'b0, 1'b1, MUL, 8'h10, 8'h10);
      drive(1'b1, 1'b0, NOP, 8'h00, 8'h00);
      idle();
      chk_out("abort_rst", 1'b0, 1'b0, 1'b0, 16'h0000);
      idle();
      idle();
      chk_out("abort_k3", 1'b0, 1'b0, 1'b0, 16'h0000);
      drive(1'b0, 1'b1, AND, 8'hF0, 8'h3C);
      idle();
      idle();
      chk_out("and_after_abort", 1'b0, 1'b1, 1'b0, 16'h0030);

      // Operands change on every cycle while a MUL is in flight.
      drive(1'b0, 1'b1, MUL, 8'h0C, 8'h0A);
      for (int i = 0; i < LAT; i++)
         drive(1'b0, 1'b0, 3'($urandom_range(7)), 8'($urandom), 8'($urandom));
      idle();
      chk_out("mul_latched", 1'b0, 1'b1, 1'b0, 16'h0078);

      // Randomised traffic, including held start and occasional resets.
      for (int i = 0; i < 400; i++)
         drive(($urandom_range(49) == 0), 1'($urandom), 3'($urandom_range(7)),
               8'($urandom), 8'($urandom));

      for (int i = 0; i < 20 && q.size() > 0; i++) idle();
      idle();
      idle();
      if (q.size() != 0) begin
         n_chk++;
         $display("FAIL drain: got %0d outstanding ops required 0", q.size());
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
